// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the 3x3 Sobel matrix: line buffers, row taps, window tagging,
// end-of-frame pipeline flush and a 2-entry result slot with skid.
module sobel_window_ctrl #(
  parameter int PIC_WIDTH  = 250,
  parameter int PIC_HEIGHT = 250,
  parameter int DW         = 8,
  parameter int MAT_LAT    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  input  logic          out_ready,
  output logic          mat_valid,
  output logic [DW-1:0] mat_din1,
  output logic [DW-1:0] mat_din2,
  output logic [DW-1:0] mat_din3,
  input  logic [DW-1:0] mat_dout,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [8:0]    out_row,
  output logic [8:0]    out_col,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic       ok;
    logic [8:0] row;
    logic [8:0] col;
  } tag_t;

  // live=1: data is still the current mat_dout and is captured at the next matrix beat
  typedef struct packed {
    logic          vld;
    logic          live;
    logic [8:0]    row;
    logic [8:0]    col;
    logic [DW-1:0] data;
  } res_t;

  localparam logic [8:0] COL_LAST = 9'(PIC_WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(PIC_HEIGHT - 1);
  localparam int AW  = $clog2(PIC_WIDTH);
  localparam int FCW = $clog2(MAT_LAT + 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(MAT_LAT - 1);

  state_t         state;
  logic [8:0]     row, col;
  logic [AW-1:0]  lb_idx;
  logic [DW-1:0]  lb0 [PIC_WIDTH];
  logic [DW-1:0]  lb1 [PIC_WIDTH];
  tag_t           mat_tag;
  tag_t           tag_pipe [MAT_LAT];
  tag_t           popped;
  res_t           res_a, res_b, res_a_n, res_b_n, res_new;
  logic [FCW-1:0] flush_cnt;
  logic           beat, flush_issue, pop, row_end;

  assign lb_idx = col[AW-1:0];
  assign popped = tag_pipe[MAT_LAT-1];
  assign row_end = (col == COL_LAST);

  // New matrix beats only when the skid slot is empty, so an in-flight result always has room
  assign s_ready     = (state == FILL) | ((state == RUN) & out_ready & ~res_b.vld);
  assign beat        = s_valid & s_ready;
  assign flush_issue = (state == FLUSH) & out_ready & ~res_b.vld;
  assign pop         = res_a.vld & out_ready;

  assign busy      = (state != IDLE);
  assign out_valid = res_a.vld;
  assign out_row   = res_a.row;
  assign out_col   = res_a.col;
  assign out_data  = res_a.live ? mat_dout : res_a.data;

  always_comb begin
    res_a_n = res_a;
    res_b_n = res_b;
    res_new = '0;
    res_new.vld  = 1'b1;
    res_new.live = 1'b1;
    res_new.row  = popped.row - 9'd1;
    res_new.col  = popped.col - 9'd1;
    if (mat_valid) begin
      if (res_a_n.live) begin
        res_a_n.data = mat_dout;
        res_a_n.live = 1'b0;
      end
      if (res_b_n.live) begin
        res_b_n.data = mat_dout;
        res_b_n.live = 1'b0;
      end
    end
    if (pop) begin
      res_a_n = res_b_n;
      res_b_n = '0;
    end
    if (mat_valid && popped.ok) begin
      if (!res_a_n.vld) res_a_n = res_new;
      else              res_b_n = res_new;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      lb0[lb_idx] <= lb1[lb_idx];
      lb1[lb_idx] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      mat_valid  <= 1'b0;
      mat_din1   <= '0;
      mat_din2   <= '0;
      mat_din3   <= '0;
      mat_tag    <= '0;
      res_a      <= '0;
      res_b      <= '0;
      flush_cnt  <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < MAT_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      mat_valid  <= 1'b0;
      frame_done <= 1'b0;
      res_a      <= res_a_n;
      res_b      <= res_b_n;
      if (mat_valid) begin
        tag_pipe[0] <= mat_tag;
        for (int i = 1; i < MAT_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
      case (state)
        IDLE: if (start) begin
          state     <= FILL;
          row       <= '0;
          col       <= '0;
          flush_cnt <= '0;
        end
        FILL, RUN: if (beat) begin
          col <= row_end ? 9'd0 : col + 9'd1;
          if (row_end) row <= row + 9'd1;
          if (state == RUN) begin
            mat_valid <= 1'b1;
            mat_din1  <= lb0[lb_idx];
            mat_din2  <= lb1[lb_idx];
            mat_din3  <= s_data;
            mat_tag   <= tag_t'{ok: (col >= 9'd2), row: row, col: col};
          end
          if (state == FILL && row == 9'd1 && row_end) state <= RUN;
          if (state == RUN && row == ROW_LAST && row_end) state <= FLUSH;
        end
        FLUSH: if (flush_issue) begin
          mat_valid <= 1'b1;
          mat_din1  <= '0;
          mat_din2  <= '0;
          mat_din3  <= '0;
          mat_tag   <= '0;
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FLUSH_LAST) state <= DONE;
        end
        DONE: if (!mat_valid && pop && !res_b.vld) begin
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench: 8x5 frames through the controller with a behavioural 2-beat Sobel matrix.
module tb_sobel_window_ctrl;
  localparam int W = 8;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_ready;
  logic       out_ready = 1'b0;
  logic       mat_valid;
  logic [7:0] mat_din1, mat_din2, mat_din3, mat_dout;
  logic       out_valid;
  logic [7:0] out_data;
  logic [8:0] out_row, out_col;
  logic       busy, frame_done;

  int checks = 0;
  int errors = 0;
  int mv_cnt, fd_cnt, fill_bad, sr_bad;
  logic [31:0] resq[$];

  sobel_window_ctrl #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .DW(8), .MAT_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .out_ready(out_ready), .mat_valid(mat_valid),
    .mat_din1(mat_din1), .mat_din2(mat_din2), .mat_din3(mat_din3), .mat_dout(mat_dout),
    .out_valid(out_valid), .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sob(input int l0, l1, l2, m0, m2, r0, r1, r2);
    int gx, gy, mag;
    gx = (r0 + 2*r1 + r2) - (l0 + 2*l1 + l2);
    gy = (l2 + 2*m2 + r2) - (l0 + 2*m0 + r0);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    mag = gx + gy;
    return (mag > 255) ? 8'd255 : 8'(mag);
  endfunction

  // Matrix stand-in: result after beat k is the window completed at beat k-2
  logic [7:0] wd [3][3];
  logic [7:0] p0, p1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) wd[i][j] <= '0;
      p0 <= '0; p1 <= '0; mat_dout <= '0;
    end else if (mat_valid) begin
      for (int j = 0; j < 3; j++) begin
        wd[0][j] <= wd[1][j];
        wd[1][j] <= wd[2][j];
      end
      wd[2][0] <= mat_din1;
      wd[2][1] <= mat_din2;
      wd[2][2] <= mat_din3;
      p0 <= sob(wd[1][0], wd[1][1], wd[1][2], wd[2][0], wd[2][2], mat_din1, mat_din2, mat_din3);
      p1 <= p0;
      mat_dout <= p1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int img, input int idx);
    int r, c;
    r = idx / W;
    c = idx % W;
    case (img)
      0:       return 8'(c + 8*r);
      1:       return 8'h40;
      default: return (c >= 4) ? 8'd100 : 8'd0;
    endcase
  endfunction

  task automatic run_frame(input int img, input bit tog, input bit rnd, input bit or0_fill,
                           input int start_at, input int rst_at);
    int idx;
    int post;
    bit beat;
    bit started;
    idx = 0; post = -1; started = 1'b0;
    resq.delete();
    mv_cnt = 0; fd_cnt = 0; fill_bad = 0; sr_bad = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 0; cyc < 3000 && post != 0; cyc++) begin
      s_valid   = (idx < W*H) && (!tog || cyc[0]);
      s_data    = pix(img, idx);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : !(or0_fill && idx < 2*W);
      start     = (idx == start_at) && !started;
      if (start) started = 1'b1;
      if (idx == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mat_valid", 32'(mat_valid), 32'd0);
        chk("rst_taps", {8'd0, mat_din1, mat_din2, mat_din3}, 32'd0);
        chk("rst_out", {out_valid, frame_done, out_row, out_col, out_data}, 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        start = 1'b0; s_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        return;
      end
      #1;
      beat = s_valid && s_ready;
      if (or0_fill && idx < 2*W && !s_ready) sr_bad++;
      if (out_valid && out_ready) resq.push_back({6'd0, out_row, out_col, out_data});
      @(posedge clk);
      @(negedge clk);
      if (beat) idx++;
      if (mat_valid) begin
        mv_cnt++;
        if (idx <= 2*W) fill_bad++;
      end
      if (frame_done) begin
        fd_cnt++;
        if (post < 0) post = 3;
      end
      if (post > 0) post--;
    end
    start = 1'b0; s_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic check_frame(input int img, input string name);
    logic [7:0] ev;
    int r, c;
    chk({name, "_count"}, 32'(resq.size()), 32'd18);
    chk({name, "_frame_done"}, 32'(fd_cnt), 32'd1);
    chk({name, "_mat_beats"}, 32'(mv_cnt), 32'(3*W + 2));
    chk({name, "_fill_mat_valid"}, 32'(fill_bad), 32'd0);
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    for (int i = 0; i < resq.size() && i < 18; i++) begin
      r = 1 + i / 6;
      c = 1 + i % 6;
      case (img)
        0:       ev = 8'd72;
        1:       ev = 8'd0;
        default: ev = (c == 3 || c == 4) ? 8'd255 : 8'd0;
      endcase
      chk({name, "_result"}, resq[i], {6'd0, 9'(r), 9'(c), ev});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    chk("reset_mat", {7'd0, mat_valid, mat_din1, mat_din2, mat_din3}, 32'd0);
    chk("reset_out", {out_valid, frame_done, out_row, out_col, out_data}, 32'd0);
    rst_n = 1'b1;

    // ramp image, start pulse mid-RUN must be ignored
    run_frame(0, 1'b0, 1'b0, 1'b0, 25, -1);
    check_frame(0, "ramp");

    // flat image, out_ready held low through the fill rows
    run_frame(1, 1'b0, 1'b0, 1'b1, -1, -1);
    check_frame(1, "flat");
    chk("fill_s_ready_or0", 32'(sr_bad), 32'd0);

    run_frame(2, 1'b0, 1'b0, 1'b0, -1, -1);
    check_frame(2, "vedge");

    // s_valid toggling with random backpressure
    run_frame(0, 1'b1, 1'b1, 1'b0, -1, -1);
    check_frame(0, "stall");

    // abort at row 2 col 3, then a clean frame
    run_frame(0, 1'b0, 1'b0, 1'b0, -1, 19);
    repeat (2) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    run_frame(0, 1'b0, 1'b0, 1'b0, -1, -1);
    check_frame(0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
